// File: rtl/punc_control_pkg.sv
// ============================================================================
//  Module   : punc_control_pkg
//  Brief    : Shared encodings for the PUnC control unit (opcodes, states, selects).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package punc_control_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_op_br   = 4'b0000;
    localparam logic [3:0] c_op_add  = 4'b0001;
    localparam logic [3:0] c_op_ld   = 4'b0010;
    localparam logic [3:0] c_op_st   = 4'b0011;
    localparam logic [3:0] c_op_jsr  = 4'b0100;
    localparam logic [3:0] c_op_and  = 4'b0101;
    localparam logic [3:0] c_op_ldr  = 4'b0110;
    localparam logic [3:0] c_op_str  = 4'b0111;
    localparam logic [3:0] c_op_rti  = 4'b1000;
    localparam logic [3:0] c_op_not  = 4'b1001;
    localparam logic [3:0] c_op_ldi  = 4'b1010;
    localparam logic [3:0] c_op_sti  = 4'b1011;
    localparam logic [3:0] c_op_jmp  = 4'b1100;
    localparam logic [3:0] c_op_res  = 4'b1101;
    localparam logic [3:0] c_op_lea  = 4'b1110;
    localparam logic [3:0] c_op_trap = 4'b1111;

    localparam logic [1:0] c_pc_sel_off9  = 2'd0;
    localparam logic [1:0] c_pc_sel_off11 = 2'd1;
    localparam logic [1:0] c_pc_sel_rp    = 2'd2;

    localparam logic [1:0] c_mem_r_pc   = 2'd0;
    localparam logic [1:0] c_mem_r_off9 = 2'd1;
    localparam logic [1:0] c_mem_r_rp6  = 2'd2;
    localparam logic [1:0] c_mem_r_temp = 2'd3;

    localparam logic [1:0] c_mem_w_off9 = 2'd0;
    localparam logic [1:0] c_mem_w_temp = 2'd2;

    localparam logic [1:0] c_rf_wd_alu  = 2'd0;
    localparam logic [1:0] c_rf_wd_mem  = 2'd1;
    localparam logic [1:0] c_rf_wd_pc   = 2'd2;
    localparam logic [1:0] c_rf_wd_off9 = 2'd3;

    localparam logic c_rf_wa_ir = 1'b0;
    localparam logic c_rf_wa_r7 = 1'b1;

    localparam logic c_rp_ir86  = 1'b0;
    localparam logic c_rp_ir119 = 1'b1;

    localparam logic [1:0] c_alu_add  = 2'd0;
    localparam logic [1:0] c_alu_and  = 2'd1;
    localparam logic [1:0] c_alu_not  = 2'd2;
    localparam logic [1:0] c_alu_pass = 2'd3;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_r_addr_sel;
        logic [1:0] mem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel;
    } ctrl_t;

    // LDI/STI/STR need a second execute cycle to go through the temp register.
    function automatic logic is_two_phase(input logic [3:0] op);
        return (op == c_op_ldi) || (op == c_op_sti) || (op == c_op_str);
    endfunction

endpackage

`default_nettype wire

// File: rtl/punc_control_decode.sv
// ============================================================================
//  Module   : punc_control_decode
//  Brief    : Combinational map from (state, ir, nzp_true) to datapath strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module punc_control_decode
    import punc_control_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        nzp_true,
    output ctrl_t       ctrl
);

    logic [3:0] w_op;
    logic       w_unused_ir_bits;

    assign w_op             = ir[15:12];
    assign w_unused_ir_bits = ^{ir[10:6], ir[4:0]};

    always_comb begin
        ctrl = '0;
        case (state)
            S_INIT: begin
                ctrl.pc_clr  = 1'b1;
                ctrl.ir_clr  = 1'b1;
                ctrl.nzp_clr = 1'b1;
            end
            S_FETCH: begin
                ctrl.mem_rd         = 1'b1;
                ctrl.mem_r_addr_sel = c_mem_r_pc;
                ctrl.ir_ld          = 1'b1;
                ctrl.pc_inc         = 1'b1;
            end
            S_EXEC: begin
                case (w_op)
                    c_op_add, c_op_and: begin
                        ctrl.rf_rp_addr_sel    = c_rp_ir86;
                        ctrl.rf_rp_rd          = 1'b1;
                        ctrl.rf_rq_rd          = 1'b1;
                        ctrl.alu_first_val_sel = ir[5];
                        ctrl.alu_sel           = (w_op == c_op_add) ? c_alu_add : c_alu_and;
                        ctrl.rf_w_addr_sel     = c_rf_wa_ir;
                        ctrl.rf_w_data_sel     = c_rf_wd_alu;
                        ctrl.rf_w_wr           = 1'b1;
                        ctrl.nzp_ld            = 1'b1;
                    end
                    c_op_not: begin
                        ctrl.rf_rp_addr_sel = c_rp_ir86;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.alu_sel        = c_alu_not;
                        ctrl.rf_w_wr        = 1'b1;
                        ctrl.nzp_ld         = 1'b1;
                    end
                    c_op_br: begin
                        ctrl.pc_sel = c_pc_sel_off9;
                        ctrl.pc_ld  = nzp_true;
                    end
                    c_op_jmp: begin
                        ctrl.rf_rp_addr_sel = c_rp_ir86;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.pc_sel         = c_pc_sel_rp;
                        ctrl.pc_ld          = 1'b1;
                    end
                    c_op_jsr: begin
                        ctrl.rf_w_addr_sel = c_rf_wa_r7;
                        ctrl.rf_w_data_sel = c_rf_wd_pc;
                        ctrl.rf_w_wr       = 1'b1;
                        ctrl.pc_ld         = 1'b1;
                        ctrl.pc_sel        = ir[11] ? c_pc_sel_off11 : c_pc_sel_rp;
                        ctrl.rf_rp_rd      = ~ir[11];
                    end
                    c_op_ld, c_op_ldr: begin
                        ctrl.mem_rd         = 1'b1;
                        ctrl.mem_r_addr_sel = (w_op == c_op_ld) ? c_mem_r_off9 : c_mem_r_rp6;
                        // LDR forms its address from Rp, so the base register is read.
                        ctrl.rf_rp_rd       = (w_op == c_op_ldr);
                        ctrl.rf_w_data_sel  = c_rf_wd_mem;
                        ctrl.rf_w_wr        = 1'b1;
                        ctrl.nzp_ld         = 1'b1;
                    end
                    c_op_lea: begin
                        ctrl.rf_w_data_sel = c_rf_wd_off9;
                        ctrl.rf_w_wr       = 1'b1;
                        ctrl.nzp_ld        = 1'b1;
                    end
                    c_op_st: begin
                        ctrl.rf_rp_addr_sel = c_rp_ir119;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.mem_wr         = 1'b1;
                        ctrl.mem_w_addr_sel = c_mem_w_off9;
                    end
                    c_op_ldi, c_op_sti: begin
                        ctrl.mem_rd         = 1'b1;
                        ctrl.mem_r_addr_sel = c_mem_r_off9;
                        ctrl.temp_ld        = 1'b1;
                    end
                    c_op_str: begin
                        ctrl.rf_rp_addr_sel = c_rp_ir86;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.temp_ld        = 1'b1;
                    end
                    c_op_rti, c_op_res, c_op_trap: ;
                    default: ;
                endcase
            end
            S_EXEC2: begin
                case (w_op)
                    c_op_ldi: begin
                        ctrl.mem_rd         = 1'b1;
                        ctrl.mem_r_addr_sel = c_mem_r_temp;
                        ctrl.rf_w_data_sel  = c_rf_wd_mem;
                        ctrl.rf_w_wr        = 1'b1;
                        ctrl.nzp_ld         = 1'b1;
                    end
                    c_op_sti, c_op_str: begin
                        ctrl.rf_rp_addr_sel = c_rp_ir119;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.mem_wr         = 1'b1;
                        ctrl.mem_w_addr_sel = c_mem_w_temp;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/punc_control.sv
// ============================================================================
//  Module   : punc_control
//  Brief    : PUnC LC3 control sequencer; PUNC_TRAP_HALT_EN makes opcode 1111 halt.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module punc_control
    import punc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_true,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,
    output logic        ir_ld,
    output logic        ir_clr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_r_addr_sel,
    output logic [1:0]  mem_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_rp_addr_sel,
    output logic        rf_rp_rd,
    output logic        rf_rq_rd,
    output logic        temp_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,
    output logic [1:0]  alu_sel,
    output logic        alu_first_val_sel
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
`ifdef PUNC_TRAP_HALT_EN
                w_next_state = (ir[15:12] == c_op_trap) ? S_HALT : S_EXEC;
`else
                w_next_state = S_EXEC;
`endif
            end
            S_EXEC:   w_next_state = is_two_phase(ir[15:12]) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_INIT;
        endcase
    end

    // Asynchronous reset so a write in flight is dropped the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    punc_control_decode u_decode (
        .state    (r_state),
        .ir       (ir),
        .nzp_true (nzp_true),
        .ctrl     (w_ctrl)
    );

    assign pc_ld             = w_ctrl.pc_ld;
    assign pc_clr            = w_ctrl.pc_clr;
    assign pc_inc            = w_ctrl.pc_inc;
    assign pc_sel            = w_ctrl.pc_sel;
    assign ir_ld             = w_ctrl.ir_ld;
    assign ir_clr            = w_ctrl.ir_clr;
    assign mem_rd            = w_ctrl.mem_rd;
    assign mem_wr            = w_ctrl.mem_wr;
    assign mem_r_addr_sel    = w_ctrl.mem_r_addr_sel;
    assign mem_w_addr_sel    = w_ctrl.mem_w_addr_sel;
    assign rf_w_data_sel     = w_ctrl.rf_w_data_sel;
    assign rf_w_addr_sel     = w_ctrl.rf_w_addr_sel;
    assign rf_w_wr           = w_ctrl.rf_w_wr;
    assign rf_rp_addr_sel    = w_ctrl.rf_rp_addr_sel;
    assign rf_rp_rd          = w_ctrl.rf_rp_rd;
    assign rf_rq_rd          = w_ctrl.rf_rq_rd;
    assign temp_ld           = w_ctrl.temp_ld;
    assign nzp_ld            = w_ctrl.nzp_ld;
    assign nzp_clr           = w_ctrl.nzp_clr;
    assign alu_sel           = w_ctrl.alu_sel;
    assign alu_first_val_sel = w_ctrl.alu_first_val_sel;

endmodule

`default_nettype wire
